ex_mem_skid_reg: RTL and testbench

- Parametrised EX→MEM pipeline boundary register.
- Adds valid/ready handshake, a two-entry skid buffer for back-pressure, synchronous flush (bubble insertion), control gating on bubbles, and a saturating back-pressure counter.
- Sits between the execute-stage ALU result path and the data-memory stage. It replaces the plain free-running boundary register wherever the memory stage can stall.

---
 rtl/ex_mem_skid_reg.sv | 109 ++++++++++
 tb/tb_ex_mem_skid_reg.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/ex_mem_skid_reg.sv
// EX->MEM boundary register with valid/ready handshake, two-entry skid buffer,
// synchronous flush, bubble control gating and a saturating back-pressure counter.
//
//   occupancy | meaning
//   ----------+------------------------------------------------
//   EMPTY     | main and skid empty, ready_o=1
//   ONE       | main valid (drives outputs), skid empty, ready_o=1
//   FULL      | main and skid valid, ready_o=0, valid_i ignored
module ex_mem_skid_reg #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5,
   parameter int CTRL_W = 3,
   parameter int CNT_W  = 16
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              flush_i,
   input  logic              valid_i,
   output logic              ready_o,
   input  logic [DATA_W-1:0] alu_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [RD_W-1:0]   rd_i,
   input  logic [CTRL_W-1:0] ctrl_i,
   output logic              valid_o,
   input  logic              ready_i,
   output logic [DATA_W-1:0] alu_o,
   output logic [DATA_W-1:0] data_o,
   output logic [RD_W-1:0]   rd_o,
   output logic [CTRL_W-1:0] ctrl_o,
   output logic [1:0]        count_o,
   output logic [CNT_W-1:0]  stall_cnt_o
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic              main_valid;
   logic [DATA_W-1:0] main_alu;
   logic [DATA_W-1:0] main_data;
   logic [RD_W-1:0]   main_rd;
   logic [CTRL_W-1:0] main_ctrl;

   logic              skid_valid;
   logic [DATA_W-1:0] skid_alu;
   logic [DATA_W-1:0] skid_data;
   logic [RD_W-1:0]   skid_rd;
   logic [CTRL_W-1:0] skid_ctrl;

   logic [CNT_W-1:0]  stall_cnt;

   // ready_o depends only on registered state, never on ready_i
   assign ready_o     = !skid_valid;
   assign valid_o     = main_valid;
   assign alu_o       = main_alu;
   assign data_o      = main_data;
   assign rd_o        = main_rd;
   assign ctrl_o      = main_valid ? main_ctrl : '0;
   assign count_o     = {1'b0, main_valid} + {1'b0, skid_valid};
   assign stall_cnt_o = stall_cnt;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         main_valid <= 1'b0;
         main_alu   <= '0;
         main_data  <= '0;
         main_rd    <= '0;
         main_ctrl  <= '0;
         skid_valid <= 1'b0;
         skid_alu   <= '0;
         skid_data  <= '0;
         skid_rd    <= '0;
         skid_ctrl  <= '0;
      end else if (flush_i) begin
         main_valid <= 1'b0;
         skid_valid <= 1'b0;
      end else if (skid_valid) begin
         if (ready_i) begin
            main_alu   <= skid_alu;
            main_data  <= skid_data;
            main_rd    <= skid_rd;
            main_ctrl  <= skid_ctrl;
            skid_valid <= 1'b0;
         end
      end else if (!main_valid || ready_i) begin
         // main is free or draining this cycle: new entry goes straight to main
         main_valid <= valid_i;
         if (valid_i) begin
            main_alu  <= alu_i;
            main_data <= data_i;
            main_rd   <= rd_i;
            main_ctrl <= ctrl_i;
         end
      end else if (valid_i) begin
         skid_valid <= 1'b1;
         skid_alu   <= alu_i;
         skid_data  <= data_i;
         skid_rd    <= rd_i;
         skid_ctrl  <= ctrl_i;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         stall_cnt <= '0;
      end else if (main_valid && !ready_i && (stall_cnt != CNT_MAX)) begin
         stall_cnt <= stall_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_ex_mem_skid_reg.sv
// Scoreboard bench for ex_mem_skid_reg: the driver queues expected entries,
// a negedge monitor pops and compares each accepted output.
module tb_ex_mem_skid_reg;

   localparam int DATA_W = 32;
   localparam int RD_W   = 5;
   localparam int CTRL_W = 3;
   localparam int CNT_W  = 3;

   logic              clk_i = 1'b0;
   logic              rst_i = 1'b0;
   logic              flush_i = 1'b0;
   logic              valid_i = 1'b0;
   logic              ready_o;
   logic [DATA_W-1:0] alu_i = '0;
   logic [DATA_W-1:0] data_i = '0;
   logic [RD_W-1:0]   rd_i = '0;
   logic [CTRL_W-1:0] ctrl_i = '0;
   logic              valid_o;
   logic              ready_i = 1'b0;
   logic [DATA_W-1:0] alu_o;
   logic [DATA_W-1:0] data_o;
   logic [RD_W-1:0]   rd_o;
   logic [CTRL_W-1:0] ctrl_o;
   logic [1:0]        count_o;
   logic [CNT_W-1:0]  stall_cnt_o;

   typedef struct {
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] data;
      logic [RD_W-1:0]   rd;
      logic [CTRL_W-1:0] ctrl;
   } item_t;

   item_t exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   ex_mem_skid_reg #(
      .DATA_W(DATA_W), .RD_W(RD_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
   ) dut (
      .clk_i(clk_i), .rst_i(rst_i), .flush_i(flush_i),
      .valid_i(valid_i), .ready_o(ready_o),
      .alu_i(alu_i), .data_i(data_i), .rd_i(rd_i), .ctrl_i(ctrl_i),
      .valid_o(valid_o), .ready_i(ready_i),
      .alu_o(alu_o), .data_o(data_o), .rd_o(rd_o), .ctrl_o(ctrl_o),
      .count_o(count_o), .stall_cnt_o(stall_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic item_t mk(input logic [DATA_W-1:0] a, input logic [CTRL_W-1:0] c);
      item_t it;
      it.alu  = a;
      it.data = a ^ 32'hA5A5_0000;
      it.rd   = a[RD_W-1:0];
      it.ctrl = c;
      return it;
   endfunction

   task automatic drive(input logic [DATA_W-1:0] a, input logic [CTRL_W-1:0] c, input bit accept);
      item_t it;
      it      = mk(a, c);
      valid_i = 1'b1;
      alu_i   = it.alu;
      data_i  = it.data;
      rd_i    = it.rd;
      ctrl_i  = it.ctrl;
      if (accept) exp_q.push_back(it);
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic do_reset();
      rst_i = 1'b1;
      exp_q.delete();
      repeat (2) @(posedge clk_i);
      #3 rst_i = 1'b0;
      step();
   endtask

   // Monitor: every MEM-side handshake must match the head of the scoreboard
   always @(negedge clk_i) begin
      if (!rst_i && valid_o && ready_i) begin
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_out: got alu %0h with empty scoreboard at %0t", alu_o, $time);
         end else begin
            item_t e;
            e = exp_q.pop_front();
            check("out_alu", alu_o, e.alu);
            check("out_data", data_o, e.data);
            check("out_rd", 32'(rd_o), 32'(e.rd));
            check("out_ctrl", 32'(ctrl_o), 32'(e.ctrl));
         end
      end
   end

   initial begin
      // Reset state
      #1 rst_i = 1'b1;
      #2;
      check("rst_valid", 32'(valid_o), 0);
      check("rst_count", 32'(count_o), 0);
      check("rst_stall", 32'(stall_cnt_o), 0);
      check("rst_alu", alu_o, 0);
      check("rst_ctrl", 32'(ctrl_o), 0);
      do_reset();
      check("rst_ready", 32'(ready_o), 1);

      // Streaming at full throughput
      ready_i = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(32'(i), 3'(i), 1'b1);
         check("str_ready", 32'(ready_o), 1);
         if (i > 1) check("str_count", 32'(count_o), 1);
         step();
      end
      valid_i = 1'b0;
      check("str_last_count", 32'(count_o), 1);
      step();
      check("str_drain_count", 32'(count_o), 0);
      check("str_queue_empty", 32'(exp_q.size()), 0);

      // Back-pressure with skid
      do_reset();
      ready_i = 1'b1;
      drive(32'd10, 3'b101, 1'b1);
      step();
      ready_i = 1'b0;
      drive(32'd11, 3'b011, 1'b1);
      check("bp_ready_one", 32'(ready_o), 1);
      step();
      drive(32'd12, 3'b110, 1'b0);
      check("bp_ready_full", 32'(ready_o), 0);
      check("bp_count_full", 32'(count_o), 2);
      repeat (3) step();
      check("bp_hold_ready", 32'(ready_o), 0);
      check("bp_hold_count", 32'(count_o), 2);
      check("bp_stall", 32'(stall_cnt_o), 4);
      ready_i = 1'b1;
      step();
      check("bp_rel_ready", 32'(ready_o), 1);
      check("bp_rel_count", 32'(count_o), 1);
      exp_q.push_back(mk(32'd12, 3'b110));
      step();
      valid_i = 1'b0;
      check("bp_last_count", 32'(count_o), 1);
      step();
      check("bp_drain_count", 32'(count_o), 0);
      check("bp_stall_final", 32'(stall_cnt_o), 4);
      check("bp_queue_empty", 32'(exp_q.size()), 0);

      // Flush while FULL, with a competing input
      ready_i = 1'b0;
      drive(32'h20, 3'b010, 1'b1);
      step();
      drive(32'h21, 3'b100, 1'b1);
      step();
      check("fl_count_full", 32'(count_o), 2);
      flush_i = 1'b1;
      drive(32'hDEAD, 3'b001, 1'b0);
      exp_q.delete();
      step();
      flush_i = 1'b0;
      valid_i = 1'b0;
      check("fl_valid", 32'(valid_o), 0);
      check("fl_ctrl", 32'(ctrl_o), 0);
      check("fl_count", 32'(count_o), 0);
      check("fl_ready", 32'(ready_o), 1);
      ready_i = 1'b1;
      repeat (2) step();
      check("fl_still_empty", 32'(valid_o), 0);
      drive(32'h30, 3'b111, 1'b1);
      step();
      valid_i = 1'b0;
      step();
      check("fl_queue_empty", 32'(exp_q.size()), 0);

      // Bubble gating: control on an idle input never leaks
      valid_i = 1'b0;
      ctrl_i  = 3'b111;
      alu_i   = 32'hBAD;
      repeat (3) step();
      check("bub_valid", 32'(valid_o), 0);
      check("bub_ctrl", 32'(ctrl_o), 0);

      // Stall counter saturation
      do_reset();
      ready_i = 1'b0;
      drive(32'h40, 3'b001, 1'b1);
      step();
      valid_i = 1'b0;
      repeat (6) step();
      check("sat_mid", 32'(stall_cnt_o), 6);
      repeat (4) step();
      check("sat_final", 32'(stall_cnt_o), 7);

      // Asynchronous reset while FULL
      drive(32'h41, 3'b010, 1'b0);
      step();
      valid_i = 1'b0;
      check("ar_count_full", 32'(count_o), 2);
      #2 rst_i = 1'b1;
      #1;
      check("ar_valid", 32'(valid_o), 0);
      check("ar_count", 32'(count_o), 0);
      check("ar_stall", 32'(stall_cnt_o), 0);
      check("ar_alu", alu_o, 0);
      check("ar_ctrl", 32'(ctrl_o), 0);
      exp_q.delete();
      @(posedge clk_i);
      #3 rst_i = 1'b0;
      step();
      check("ar_ready", 32'(ready_o), 1);
      check("ar_count_after", 32'(count_o), 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
